mat_fetch: RTL and testbench
============================

# mat_fetch

Fetch stage feeding the minilab matrix-vector datapath. On a `start` pulse it reads ROWS matrix-row words plus one vector word from an Avalon-MM read master port, unpacks each 64-bit word into DATA_WIDTH-bit bytes, and pushes them into the downstream per-row FIFOs and the vector FIFO, raising `done` when all are loaded. It sits between the on-chip memory and the FIFO/MAC array instantiated in the Minilab top.

## Interface
- DATA_WIDTH, 8: byte width pushed into each FIFO
- ROWS, 8: number of matrix rows; one row FIFO per row
- COLS, 8: bytes per memory word; COLS*DATA_WIDTH = word width
- ADDR_WIDTH, 32: Avalon address width

Ports:
- clk  in  1  system clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a fetch; ignored unless state is IDLE or DONE
- busy  out  1  high in REQ, WAIT_DATA, UNPACK
- done  out  1  high in DONE; held until next accepted `start`
- address  out  ADDR_WIDTH  word address, 0..ROWS
- read  out  1  Avalon read request
- waitrequest  in  1  slave stall; request held while high
- readdata  in  COLS*DATA_WIDTH  returned word
- readdatavalid  in  1  qualifies `readdata`
- fifo_wren  out  ROWS+1  one-hot write strobe; bits 0..ROWS-1 row FIFOs, bit ROWS vector FIFO
- fifo_wdata  out  DATA_WIDTH  byte being written
- fifo_full  in  ROWS+1  per-FIFO full flags

## Operation
- States: IDLE, REQ, WAIT_DATA, UNPACK, DONE.
- IDLE/DONE + start -> REQ; word index w=0, done cleared.
- REQ: read=1, address=w. Held stable while waitrequest=1. On read && !waitrequest -> WAIT_DATA.
- WAIT_DATA: read=0. On readdatavalid, latch readdata into word register, byte index b=0 -> UNPACK. readdatavalid in any other state is ignored.
- UNPACK: byte b = word[(COLS-1-b)*DATA_WIDTH +: DATA_WIDTH] (MSB byte first). If !fifo_full[w]: fifo_wren[w]=1, fifo_wdata=byte, b++. If full: no strobe, b held (stall, no drop).
- After byte COLS-1 written: if w==ROWS -> DONE, else w++ -> REQ.
- Word w<ROWS targets row FIFO w; word ROWS targets vector FIFO.
- DONE: done=1, busy=0, no bus or FIFO activity.
- Index widths: w is clog2(ROWS+1) bits, b is clog2(COLS) bits; no wrap beyond stated ranges.

## Timing
- Reset (async assert, sync-released use): state IDLE; read=0, address=0, busy=0, done=0, fifo_wren=0, fifo_wdata=0, w=b=0. Reset mid-fetch abandons in-flight read; later readdatavalid ignored in IDLE.
- start at cycle 0 -> read high cycle 1. Zero waitrequest, readdatavalid at cycle 2 -> first fifo_wren cycle 3.
- Per word, no stalls, 1-cycle read latency: 10 cycles (REQ, WAIT_DATA, 8 UNPACK). Default full fetch: 90 cycles; done high cycle 91 after start.
- At most one read outstanding; next REQ only after previous word fully unpacked.
- All outputs registered or decoded from registered state only; no combinational path from fifo_full to read.
- start during busy: no effect.

## Structure
- Shared package minilab_pkg: fetch_state_t enum, default DATA_WIDTH/ROWS/COLS constants, word-width localparam.
- Single module; no sub-module needed (unpack mux is a few lines inline).

## Test plan
- Memory word k = {8'h(k*16+0)..8'h(k*16+7)} for k=0..8, zero waitrequest, latency 1 -> row FIFO r receives 8'h(r*16), ..., 8'h(r*16+7) in order; vector FIFO gets 8'h80..8'h87; done at cycle 91.
- waitrequest held high 3 cycles on word 2 -> read and address=2 stable all 4 cycles, exactly one acceptance, data intact.
- fifo_full[3] high for 5 cycles mid-word 3 -> no strobe during stall, no byte lost or duplicated, total latency +5.
- rst_n low during UNPACK of word 4 -> all outputs 0 immediately; late readdatavalid ignored; new start fetches from address 0.
- start pulsed while busy -> ignored; start in DONE -> done drops next cycle, fresh fetch from address 0.
- readdatavalid latency 4 cycles -> read deasserted during wait, one word per request, correct ordering.

Source files
------------

// File: rtl/minilab_pkg.sv
// ---------------------------------------------------------------------------
// minilab_pkg
// Shared definitions for the minilab matrix-vector datapath.
//   - default geometry constants (byte width, rows, bytes per word)
//   - derived word width
//   - fetch_state_t: state encoding of the mat_fetch controller
//   - fetch_is_busy(): states in which a fetch is in progress
// ---------------------------------------------------------------------------
package minilab_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROWS       = 8;
  localparam int DEF_COLS       = 8;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_WORD_WIDTH = DEF_COLS * DEF_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_UNPACK    = 3'd3,
    ST_DONE      = 3'd4
  } fetch_state_t;

  // A fetch is in progress from the bus request until the last byte is pushed.
  function automatic logic fetch_is_busy(input fetch_state_t st);
    return (st == ST_REQ) || (st == ST_WAIT_DATA) || (st == ST_UNPACK);
  endfunction

endpackage

// File: rtl/mat_fetch.sv
// ---------------------------------------------------------------------------
// mat_fetch
// Fetch stage of the minilab matrix-vector datapath. A start pulse reads
// ROWS matrix-row words followed by one vector word over an Avalon-MM read
// master, splits every word into COLS bytes (most significant byte first)
// and pushes them into the matching row FIFO (words 0..ROWS-1) or the
// vector FIFO (word ROWS). done is raised once everything is loaded.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle request; only accepted in IDLE or DONE
//   busy            fetch in progress (REQ, WAIT_DATA, UNPACK)
//   done            all words loaded; held until the next accepted start
//   address, read   Avalon read request (word address 0..ROWS)
//   waitrequest     slave stall; request held stable while high
//   readdata,
//   readdatavalid   returned word and its qualifier
//   fifo_wren       one-hot write strobe, bit ROWS is the vector FIFO
//   fifo_wdata      byte being written
//   fifo_full       per-FIFO full flags; a full target stalls unpacking
// ---------------------------------------------------------------------------
module mat_fetch
  import minilab_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic                       read,
  input  logic                       waitrequest,
  input  logic [COLS*DATA_WIDTH-1:0] readdata,
  input  logic                       readdatavalid,
  output logic [ROWS:0]              fifo_wren,
  output logic [DATA_WIDTH-1:0]      fifo_wdata,
  input  logic [ROWS:0]              fifo_full
);

  localparam int WORD_WIDTH = COLS * DATA_WIDTH;
  localparam int W_W        = $clog2(ROWS + 1);
  localparam int B_W        = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [W_W-1:0] LAST_WORD = W_W'(ROWS);
  localparam logic [B_W-1:0] LAST_BYTE = B_W'(COLS - 1);
  localparam logic [W_W-1:0] W_ONE     = W_W'(1);
  localparam logic [B_W-1:0] B_ONE     = B_W'(1);

  fetch_state_t              state_r;
  logic [W_W-1:0]            w_r;      // word index, also the target FIFO
  logic [B_W-1:0]            b_r;      // byte index within the latched word
  logic [WORD_WIDTH-1:0]     word_r;   // word being unpacked

  logic [DATA_WIDTH-1:0]     bytes_s [COLS];
  logic [DATA_WIDTH-1:0]     byte_s;
  logic                      full_s;
  logic                      push_s;

  // Split the latched word into bytes, index 0 being the most significant.
  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      bytes_s[i] = word_r[(COLS-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Select the current byte and decide whether it can be pushed this cycle.
  always_comb begin
    byte_s = bytes_s[b_r];
    full_s = fifo_full[w_r];
    push_s = (state_r == ST_UNPACK) && !full_s;
  end

  // Output decode; everything derives from registered state, and read does
  // not depend on fifo_full.
  always_comb begin
    read       = (state_r == ST_REQ);
    busy       = fetch_is_busy(state_r);
    done       = (state_r == ST_DONE);
    address    = ADDR_WIDTH'(w_r);
    fifo_wren  = '0;
    fifo_wdata = '0;
    if (push_s) begin
      fifo_wren[w_r] = 1'b1;
      fifo_wdata     = byte_s;
    end else begin
      fifo_wren  = '0;
      fifo_wdata = '0;
    end
  end

  // Fetch controller: request, wait for data, unpack, advance to next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      w_r     <= '0;
      b_r     <= '0;
      word_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r <= ST_REQ;
            w_r     <= '0;
            b_r     <= '0;
          end
        end
        ST_REQ: begin
          // address is w_r and stays put while the slave stalls
          if (!waitrequest) begin
            state_r <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (readdatavalid) begin
            word_r  <= readdata;
            b_r     <= '0;
            state_r <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          // a full target FIFO simply holds b_r, so no byte is dropped
          if (!full_s) begin
            if (b_r == LAST_BYTE) begin
              b_r <= '0;
              if (w_r == LAST_WORD) begin
                state_r <= ST_DONE;
              end else begin
                w_r     <= w_r + W_ONE;
                state_r <= ST_REQ;
              end
            end else begin
              b_r <= b_r + B_ONE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          w_r     <= '0;
          b_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_fetch.sv
// ---------------------------------------------------------------------------
// tb_mat_fetch
// Directed bench for mat_fetch with an Avalon memory model, FIFO-full
// injection and a scoreboard of expected (fifo, byte) pushes filled when
// the memory accepts a read and drained when the DUT strobes fifo_wren.
// ---------------------------------------------------------------------------
module tb_mat_fetch;

  localparam int DW = 8;
  localparam int RW = 8;
  localparam int CL = 8;
  localparam int AW = 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [AW-1:0]     address;
  logic              read;
  logic              waitrequest;
  logic [CL*DW-1:0]  readdata;
  logic              readdatavalid;
  logic [RW:0]       fifo_wren;
  logic [DW-1:0]     fifo_wdata;
  logic [RW:0]       fifo_full;

  mat_fetch #(.DATA_WIDTH(DW), .ROWS(RW), .COLS(CL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .address(address), .read(read), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  int        exp_f[$];
  logic [7:0] exp_d[$];

  // memory / environment state
  int lat        = 1;
  int pend_cnt   = 0;
  int pend_addr  = 0;
  int exp_addr   = 0;
  int stall_addr = 2;
  int stall_left = 0;
  int stall_seen = 0;
  int full_left  = 0;
  bit full_armed = 1'b0;
  bit force_rdv  = 1'b0;
  int cnt_f [RW+1];
  int wr_total   = 0;
  int cyc_g      = 0;
  int first_wr   = -1;

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input int k);
    logic [63:0] w;
    for (int i = 0; i < CL; i++) w[(CL-1-i)*8 +: 8] = 8'(k*16 + i);
    return w;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_g++;
  end

  // Slave side: drives waitrequest, read data and FIFO-full just after each edge.
  initial begin
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0; fifo_full = '0;
    forever begin
      @(posedge clk); #1;
      readdatavalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          readdatavalid = 1'b1;
          readdata      = mem_word(pend_addr);
        end
      end
      if (force_rdv) begin
        readdatavalid = 1'b1;
        readdata      = 64'hDEAD_BEEF_CAFE_F00D;
        force_rdv     = 1'b0;
      end
      waitrequest = (read === 1'b1) && (address == AW'(stall_addr)) && (stall_left > 0);
      if (waitrequest) stall_left--;
      if (full_armed && cnt_f[3] == 4) begin
        full_armed = 1'b0;
        full_left  = 5;
      end
      fifo_full[3] = (full_left > 0);
      if (full_left > 0) full_left--;
    end
  end

  // Monitor: bus acceptances and FIFO writes, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (read === 1'b1) check(64'(pend_cnt == 0), 64'd1, "one_outstanding");
      if (read === 1'b1 && waitrequest === 1'b1) begin
        stall_seen++;
        check(64'(address), 64'(stall_addr), "stall_addr_stable");
      end
      if (read === 1'b1 && waitrequest === 1'b0) begin
        check(64'(address), 64'(exp_addr), "rd_addr");
        if (address <= AW'(RW)) begin
          for (int i = 0; i < CL; i++) begin
            exp_f.push_back(int'(address));
            exp_d.push_back(8'(int'(address)*16 + i));
          end
        end
        pend_addr = int'(address);
        pend_cnt  = lat;
        exp_addr++;
      end
      if (fifo_full !== '0) check(64'(fifo_wren & fifo_full), 64'd0, "wr_while_full");
      if (fifo_wren !== '0) begin
        int idx;
        idx = -1;
        for (int i = 0; i <= RW; i++) if (fifo_wren[i]) idx = i;
        check(64'($onehot(fifo_wren)), 64'd1, "wren_onehot");
        check(64'(exp_f.size() > 0), 64'd1, "unexpected_wr");
        if (exp_f.size() > 0) begin
          check(64'(idx), 64'(exp_f.pop_front()), "wr_fifo");
          check(64'(fifo_wdata), 64'(exp_d.pop_front()), "wr_data");
        end
        if (idx >= 0) cnt_f[idx]++;
        wr_total++;
        if (first_wr < 0) first_wr = cyc_g;
      end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i <= RW; i++) cnt_f[i] = 0;
    exp_addr = 0;
    first_wr = -1;
  endtask

  // Full fetch from a start pulse; poke>0 re-pulses start at that cycle.
  task automatic run_fetch(input int exp_done, input int exp_first, input int poke, input string tag);
    int cyc;
    int cyc0;
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1;
    cyc0  = cyc_g;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    check(64'(read), 64'd1, {tag, "_read_c1"});
    check(64'(address), 64'd0, {tag, "_addr_c1"});
    check(64'(done), 64'd0, {tag, "_done_c1"});
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke);
    end
    start = 1'b0;
    check(64'(cyc), 64'(exp_done), {tag, "_done_cycle"});
    check(64'(first_wr - cyc0), 64'(exp_first), {tag, "_first_wr"});
    check(64'(busy), 64'd0, {tag, "_busy_done"});
    check(64'(exp_f.size()), 64'd0, {tag, "_sb_empty"});
    for (int i = 0; i <= RW; i++) check(64'(cnt_f[i]), 64'(CL), {tag, "_fifo_cnt"});
  endtask

  initial begin
    int n;
    int wr_snap;
    rst_n = 1'b1;
    start = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(64'(read), 64'd0, "rst_read");
    check(64'(address), 64'd0, "rst_addr");
    check(64'(busy), 64'd0, "rst_busy");
    check(64'(done), 64'd0, "rst_done");
    check(64'(fifo_wren), 64'd0, "rst_wren");
    check(64'(fifo_wdata), 64'd0, "rst_wdata");
    rst_n = 1'b1;

    // 1: clean fetch, latency 1
    lat = 1;
    run_fetch(91, 3, -1, "f1");

    // 2: waitrequest x3 on word 2, fifo_full[3] x5, stray start while busy
    stall_left = 3; stall_addr = 2; stall_seen = 0; full_armed = 1'b1;
    run_fetch(99, 3, 20, "f2");
    check(64'(stall_seen), 64'd3, "f2_stall_cycles");
    check(64'(full_armed), 64'd0, "f2_full_fired");

    // 3: start from DONE, then reset during word 4 unpack
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check(64'(done), 64'd0, "f3_done_drop");
    check(64'(read), 64'd1, "f3_read_c1");
    check(64'(address), 64'd0, "f3_addr_c1");
    n = 0;
    while (cnt_f[4] < 3 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(64'(cnt_f[4] >= 3), 64'd1, "f3_reach_word4");
    rst_n = 1'b0;
    #1;
    check(64'(read), 64'd0, "f3_rst_read");
    check(64'(address), 64'd0, "f3_rst_addr");
    check(64'(busy), 64'd0, "f3_rst_busy");
    check(64'(done), 64'd0, "f3_rst_done");
    check(64'(fifo_wren), 64'd0, "f3_rst_wren");
    check(64'(fifo_wdata), 64'd0, "f3_rst_wdata");
    exp_f.delete();
    exp_d.delete();
    pend_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_snap = wr_total;
    force_rdv = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check(64'(busy), 64'd0, "f3_late_rdv_busy");
    check(64'(done), 64'd0, "f3_late_rdv_done");
    check(64'(wr_total), 64'(wr_snap), "f3_late_rdv_nowr");

    // 4: fresh fetch after reset with 4-cycle read latency
    lat = 4;
    run_fetch(118, 6, -1, "f4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
